// File: rtl/approx_mult_error_monitor_pkg.sv
// Shared types and width helpers for the approximate-multiplier error monitor.
// The modules derive their widths from their own W through the helper functions.
package approx_metric_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int W_DEFAULT = 8;
  localparam int PW        = 2 * W_DEFAULT;
  localparam int ED_W      = 2 * W_DEFAULT + 1;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  function automatic int diff_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/approx_mult_error_monitor_abs_err_stage.sv
// Combinational signed error (exact - approximate) and its magnitude.
// The magnitude always fits in 2*W bits, so it is formed directly in that width.
module abs_err_stage
  import approx_metric_pkg::*;
#(
  parameter int W = 8
) (
  input  logic        [2*W-1:0] i_exact,
  input  logic        [2*W-1:0] i_p_apprx,
  output logic signed [2*W:0]   o_ed,
  output logic        [2*W-1:0] o_abs_ed
);

  localparam int PROD_W = prod_width(W);

  logic signed [2*W:0] w_ed;
  logic                w_neg;

  assign w_ed  = $signed({1'b0, i_exact}) - $signed({1'b0, i_p_apprx});
  assign w_neg = w_ed[PROD_W];

  // Modulo-2^PW subtraction in the right direction yields |ed| exactly.
  assign o_ed     = w_ed;
  assign o_abs_ed = w_neg ? (i_p_apprx - i_exact) : (i_exact - i_p_apprx);

endmodule

// File: rtl/approx_mult_error_monitor.sv
// Run-controlled error-statistics accumulator for an approximate multiplier.
// Three-stage pipeline: exact product, error/magnitude, accumulate.
module approx_mult_error_monitor
  import approx_metric_pkg::*;
#(
  parameter int W     = 8,
  parameter int NS_W  = 16,
  parameter int ACC_W = 2 * W + NS_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic        [NS_W-1:0]  num_samples,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [W-1:0]     a,
  input  logic        [W-1:0]     b,
  input  logic        [2*W-1:0]   p_apprx,
  output logic                    busy,
  output logic                    done,
  output logic        [NS_W-1:0]  sample_count,
  output logic        [NS_W-1:0]  err_count,
  output logic        [ACC_W-1:0] sum_abs_ed,
  output logic signed [ACC_W:0]   sum_ed,
  output logic        [2*W-1:0]   max_abs_ed
);

  localparam int PROD_W = prod_width(W);
  localparam int DIFF_W = diff_width(W);

  state_t                    r_state, w_state_nxt;
  logic        [NS_W-1:0]    r_target, r_accepted;
  logic                      r_s1_valid, r_s2_valid, r_s3_valid;
  logic        [PROD_W-1:0]  r_s1_exact, r_s1_papprx, r_s2_abs;
  logic signed [DIFF_W-1:0]  r_s2_ed, w_ed;
  logic        [PROD_W-1:0]  w_abs;
  logic                      w_accept, w_last, w_pipe_empty;

  logic        [NS_W-1:0]    r_sample_count, r_err_count;
  logic        [ACC_W-1:0]   r_sum_abs_ed;
  logic signed [ACC_W:0]     r_sum_ed;
  logic        [PROD_W-1:0]  r_max_abs_ed;

  // A start in any state restarts, so nothing is accepted in the start cycle.
  assign in_ready     = (r_state == RUN) && (r_accepted < r_target) && !start;
  assign w_accept     = in_valid && in_ready;
  assign w_last       = (r_accepted + NS_W'(1)) == r_target;
  assign w_pipe_empty = !r_s1_valid && !r_s2_valid && !r_s3_valid;

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = (num_samples == '0) ? DONE : RUN;
    end else begin
      case (r_state)
        RUN:     if (w_accept && w_last) w_state_nxt = DRAIN;
        DRAIN:   if (w_pipe_empty)       w_state_nxt = DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_target   <= '0;
      r_accepted <= '0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_s1_valid <= w_accept;
      r_s2_valid <= r_s1_valid && !start;
      r_s3_valid <= r_s2_valid && !start;
      if (start) begin
        r_target   <= num_samples;
        r_accepted <= '0;
      end else if (w_accept) begin
        r_accepted <= r_accepted + NS_W'(1);
      end
    end
  end

  abs_err_stage #(.W(W)) u_abs_err_stage (
    .i_exact   (r_s1_exact),
    .i_p_apprx (r_s1_papprx),
    .o_ed      (w_ed),
    .o_abs_ed  (w_abs)
  );

  // NOTE: payload registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    r_s1_exact  <= PROD_W'(a) * PROD_W'(b);
    r_s1_papprx <= p_apprx;
    r_s2_ed     <= w_ed;
    r_s2_abs    <= w_abs;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      r_sample_count <= '0;
      r_err_count    <= '0;
      r_sum_abs_ed   <= '0;
      r_sum_ed       <= '0;
      r_max_abs_ed   <= '0;
    end else if (r_s2_valid) begin
      r_sample_count <= r_sample_count + NS_W'(1);
      r_err_count    <= r_err_count + NS_W'(r_s2_ed != '0);
      r_sum_abs_ed   <= r_sum_abs_ed + ACC_W'(r_s2_abs);
      r_sum_ed       <= r_sum_ed + (ACC_W+1)'(r_s2_ed);
      if (r_s2_abs > r_max_abs_ed) r_max_abs_ed <= r_s2_abs;
    end
  end

  assign busy         = (r_state == RUN) || (r_state == DRAIN);
  assign done         = (r_state == DONE);
  assign sample_count = r_sample_count;
  assign err_count    = r_err_count;
  assign sum_abs_ed   = r_sum_abs_ed;
  assign sum_ed       = r_sum_ed;
  assign max_abs_ed   = r_max_abs_ed;

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Self-checking bench: a per-cycle reference model with a scoreboard of
// accepted samples, each retired into the model exactly three cycles later.
module tb_approx_mult_error_monitor;

  localparam int W     = 8;
  localparam int NS_W  = 16;
  localparam int ACC_W = 2 * W + NS_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic        [NS_W-1:0]  num_samples;
  logic                    in_valid;
  logic                    in_ready;
  logic        [W-1:0]     a, b;
  logic        [2*W-1:0]   p_apprx;
  logic                    busy, done;
  logic        [NS_W-1:0]  sample_count, err_count;
  logic        [ACC_W-1:0] sum_abs_ed;
  logic signed [ACC_W:0]   sum_ed;
  logic        [2*W-1:0]   max_abs_ed;

  approx_mult_error_monitor #(.W(W), .NS_W(NS_W), .ACC_W(ACC_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .p_apprx      (p_apprx),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .err_count    (err_count),
    .sum_abs_ed   (sum_abs_ed),
    .sum_ed       (sum_ed),
    .max_abs_ed   (max_abs_ed)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
    end
  endtask

  typedef struct {
    int due;
    int ed;
  } sb_item_t;

  sb_item_t sb[$];
  int       cyc      = 0;
  int       m_cnt    = 0;
  int       m_err    = 0;
  longint   m_abs    = 0;
  longint   m_sum    = 0;
  int       m_max    = 0;
  int       m_target = 0;
  int       m_acc    = 0;
  bit       m_run    = 1'b0;

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_abs = 0; m_sum = 0; m_max = 0;
  endtask

  // Reference model, evaluated mid-cycle away from the active edge.
  always @(negedge clk) begin
    sb_item_t it;
    int       e, ae;
    bit       exp_ready;
    if (!rst_n) begin
      sb.delete();
      model_clear();
      m_run = 1'b0; m_acc = 0; m_target = 0;
    end else begin
      while (sb.size() > 0 && sb[0].due == cyc) begin
        it = sb.pop_front();
        ae = (it.ed < 0) ? -it.ed : it.ed;
        m_cnt++;
        if (it.ed != 0) m_err++;
        m_abs += ae;
        m_sum += it.ed;
        if (ae > m_max) m_max = ae;
      end
      check("sample_count", sample_count, m_cnt);
      check("err_count",    err_count,    m_err);
      check("sum_abs_ed",   sum_abs_ed,   m_abs);
      check("sum_ed",       sum_ed,       m_sum);
      check("max_abs_ed",   max_abs_ed,   m_max);
      exp_ready = m_run && (m_acc < m_target) && !start;
      check("in_ready", in_ready, exp_ready);
      if (start) begin
        sb.delete();
        model_clear();
        m_target = int'(num_samples);
        m_acc    = 0;
        m_run    = (num_samples != 0);
      end else if (in_valid && exp_ready) begin
        e = int'(a) * int'(b) - int'(p_apprx);
        sb.push_back('{due: cyc + 3, ed: e});
        m_acc++;
        if (m_acc == m_target) m_run = 1'b0;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start       = 1'b1;
    num_samples = NS_W'(n);
    tick();
    start       = 1'b0;
  endtask

  task automatic send(input int av, input int bv, input int pv, input int gap);
    in_valid = 1'b1;
    a        = W'(av);
    b        = W'(bv);
    p_apprx  = (2*W)'(pv);
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int k = 0;
    while (!done && k < max_cycles) begin
      tick();
      k++;
    end
    check(tag, done, 1);
  endtask

  task automatic check_final(input string tag, input int cnt, input int err,
                             input longint sabs, input longint sed, input int mx);
    check({tag, "_count"}, sample_count, cnt);
    check({tag, "_err"},   err_count,    err);
    check({tag, "_abs"},   sum_abs_ed,   sabs);
    check({tag, "_sed"},   sum_ed,       sed);
    check({tag, "_max"},   max_abs_ed,   mx);
    check({tag, "_busy"},  busy,         0);
  endtask

  initial begin
    int pa, pb, pv;
    rst_n = 1'b0; start = 1'b0; num_samples = '0; in_valid = 1'b0;
    a = '0; b = '0; p_apprx = '0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_final("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Exact products only: no error recorded.
    do_start(3);
    check("t1_busy", busy, 1);
    send(3, 5, 15, 0);
    send(255, 255, 65025, 0);
    send(0, 7, 0, 0);
    wait_done("t1_done", 20);
    check_final("t1", 3, 0, 0, 0, 0);
    repeat (2) tick();
    check("t1_done_held", done, 1);

    // Mixed-sign errors.
    do_start(2);
    send(10, 10, 96, 0);
    send(200, 100, 20010, 0);
    wait_done("t2_done", 20);
    check_final("t2", 2, 2, 14, -6, 10);

    // Same samples with gaps and an extra pulse after the run is full.
    do_start(2);
    send(10, 10, 96, 4);
    send(200, 100, 20010, 0);
    send(1, 1, 5, 0);
    check("t3_ready_low", in_ready, 0);
    wait_done("t3_done", 20);
    check_final("t3", 2, 2, 14, -6, 10);

    // Largest possible error, back to back.
    do_start(2);
    send(255, 255, 0, 0);
    send(255, 255, 0, 0);
    wait_done("t4_done", 20);
    check_final("t4", 2, 2, 130050, 130050, 65025);

    // Empty run.
    do_start(0);
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_busy_hold", busy, 0);
    end
    check_final("t5", 0, 0, 0, 0, 0);

    // Random sweep with random gaps and occasional exact products.
    do_start(20);
    for (int i = 0; i < 20; i++) begin
      pa = int'($urandom_range(0, 255));
      pb = int'($urandom_range(0, 255));
      pv = ($urandom_range(0, 2) == 0) ? pa * pb : int'($urandom_range(0, 65535));
      send(pa, pb, pv, int'($urandom_range(0, 2)));
    end
    wait_done("rnd_done", 20);

    // Reset in the middle of a run discards it.
    do_start(8);
    for (int i = 0; i < 5; i++) send(i + 3, 7, i, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_in_ready", in_ready, 0);
    check("t6_done", done, 0);
    check_final("t6_rst", 0, 0, 0, 0, 0);
    tick();
    do_start(1);
    send(2, 3, 7, 0);
    wait_done("t6_done2", 20);
    check_final("t6", 1, 1, 1, -1, 1);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
